// File: rtl/das_pkg.sv
// Shared constants, FSM state type and helpers for the delay-and-sum beamformer.
package das_pkg;

    localparam int unsigned NUM_CH   = 16;
    localparam int unsigned SAMPLE_W = 12;
    localparam int unsigned DEPTH    = 256;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned SUM_W    = 16;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SETUP,
        READ,
        SUM,
        OUT
    } das_state_t;

    // Magnitude of a signed sum; -32768 wraps to 16'h8000, which reads as 32768 unsigned.
    function automatic logic [SUM_W-1:0] abs_sum(input logic signed [SUM_W-1:0] v);
        return v[SUM_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// One channel of echo storage: single write port, registered read port (block-RAM style).
module sample_ram
    import das_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [SAMPLE_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [SAMPLE_W-1:0] o_rdata
);

    logic [SAMPLE_W-1:0] r_mem [DEPTH];
    logic [SAMPLE_W-1:0] r_rdata;

    // Synchronous write and registered read; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/das_beamformer.sv
// Delay-and-sum beamformer: captures a 16-channel frame, then rasters the pixel grid,
// summing per-channel delayed samples and streaming |sum| out over valid/ready.
`ifndef PIXEL_COLUMN
`define PIXEL_COLUMN 16
`endif
`ifndef PIXEL_ROW
`define PIXEL_ROW 16
`endif

module das_beamformer
    import das_pkg::*;
#(
    parameter  int PIXEL_COLUMN = `PIXEL_COLUMN,
    parameter  int PIXEL_ROW    = `PIXEL_ROW,
    localparam int XW           = $clog2(PIXEL_COLUMN),
    localparam int YW           = $clog2(PIXEL_ROW)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic                             i_sample_valid,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  i_sample,
    output logic signed [XW-1:0]             o_p_x,
    output logic signed [YW-1:0]             o_p_y,
    input  logic [ADDR_W-1:0]                i_delta [NUM_CH-1:0],
    output logic                             o_pix_valid,
    input  logic                             i_pix_ready,
    output logic [SUM_W-1:0]                 o_pix_data,
    output logic signed [XW-1:0]             o_pix_x,
    output logic signed [YW-1:0]             o_pix_y,
    output logic                             o_busy,
    output logic                             o_done
);

    // -N/2 and N/2-1 in XW/YW-bit two's complement.
    localparam logic signed [XW-1:0] X_MIN = {1'b1, {(XW-1){1'b0}}};
    localparam logic signed [XW-1:0] X_MAX = {1'b0, {(XW-1){1'b1}}};
    localparam logic signed [YW-1:0] Y_MIN = {1'b1, {(YW-1){1'b0}}};
    localparam logic signed [YW-1:0] Y_MAX = {1'b0, {(YW-1){1'b1}}};

    das_state_t              r_state;
    logic [ADDR_W-1:0]       r_wr_ptr;
    logic signed [XW-1:0]    r_p_x;
    logic signed [YW-1:0]    r_p_y;
    logic [ADDR_W-1:0]       r_rd_addr [NUM_CH];
    logic [SAMPLE_W-1:0]     w_rd_data [NUM_CH];
    logic                    w_we;
    logic signed [SUM_W-1:0] w_tree;
    logic                    r_pix_valid;
    logic [SUM_W-1:0]        r_pix_data;
    logic signed [XW-1:0]    r_pix_x;
    logic signed [YW-1:0]    r_pix_y;
    logic                    r_done;

    assign w_we = (r_state == CAPTURE) && i_sample_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sample_ram u_ram (
            .i_clk   (i_clk),
            .i_we    (w_we),
            .i_waddr (r_wr_ptr),
            .i_wdata (i_sample[g]),
            .i_raddr (r_rd_addr[g]),
            .o_rdata (w_rd_data[g])
        );
    end

    // Sign-extended sum of all channel read data; 16 x 12-bit cannot overflow 16 bits.
    always_comb begin
        w_tree = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w_tree = w_tree + {{(SUM_W-SAMPLE_W){w_rd_data[ch][SAMPLE_W-1]}}, w_rd_data[ch]};
        end
    end

    // Control FSM with write pointer, pixel raster counters and registered pixel output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_p_x       <= X_MIN;
            r_p_y       <= Y_MIN;
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_done      <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_rd_addr[ch] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_wr_ptr <= '0;
                        r_state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (i_sample_valid) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == ADDR_W'(DEPTH - 1)) begin
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    // Delta_generator output settles from the pixel counters within this cycle.
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        r_rd_addr[ch] <= i_delta[ch];
                    end
                    r_state <= READ;
                end
                READ: begin
                    r_state <= SUM;
                end
                SUM: begin
                    r_pix_data  <= abs_sum(w_tree);
                    r_pix_x     <= r_p_x;
                    r_pix_y     <= r_p_y;
                    r_pix_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    if (i_pix_ready) begin
                        r_pix_valid <= 1'b0;
                        if (r_p_x == X_MAX && r_p_y == Y_MAX) begin
                            r_p_x   <= X_MIN;
                            r_p_y   <= Y_MIN;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            if (r_p_x == X_MAX) begin
                                r_p_x <= X_MIN;
                                r_p_y <= r_p_y + {{(YW-1){1'b0}}, 1'b1};
                            end else begin
                                r_p_x <= r_p_x + {{(XW-1){1'b0}}, 1'b1};
                            end
                            r_state <= SETUP;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_p_x       = r_p_x;
    assign o_p_y       = r_p_y;
    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_data;
    assign o_pix_x     = r_pix_x;
    assign o_pix_y     = r_pix_y;
    assign o_busy      = (r_state != IDLE);
    assign o_done      = r_done;

endmodule

// File: tb/tb_das_beamformer.sv
// Self-checking bench for das_beamformer on a 4x4 grid with a behavioural Delta_generator.
module tb_das_beamformer;

    localparam int COL  = 4;
    localparam int ROW  = 4;
    localparam int NPIX = COL * ROW;
    localparam int XMIN = -(COL / 2);
    localparam int XMAX = COL / 2 - 1;
    localparam int YMIN = -(ROW / 2);
    // {busy, valid, done, data, pix_x, pix_y, p_x, p_y} after reset
    localparam logic [26:0] RST_VEC = {3'b000, 16'd0, 2'b00, 2'b00, 2'b10, 2'b10};

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    sval;
    logic [15:0][11:0]       samp;
    logic signed [1:0]       p_x;
    logic signed [1:0]       p_y;
    logic [7:0]              delta [15:0];
    logic                    pvalid;
    logic                    pready;
    logic [15:0]             pdata;
    logic signed [1:0]       pix_x;
    logic signed [1:0]       pix_y;
    logic                    busy;
    logic                    done;

    int n_pass;
    int n_total;
    int frame [16][256];

    das_beamformer #(
        .PIXEL_COLUMN (COL),
        .PIXEL_ROW    (ROW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_sample_valid (sval),
        .i_sample       (samp),
        .o_p_x          (p_x),
        .o_p_y          (p_y),
        .i_delta        (delta),
        .o_pix_valid    (pvalid),
        .i_pix_ready    (pready),
        .o_pix_data     (pdata),
        .o_pix_x        (pix_x),
        .o_pix_y        (pix_y),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay law: at (0,0) channels 0-3 -> 147, 4-11 -> 149, 12-15 -> 150; skewed elsewhere.
    function automatic logic [7:0] delta_f(input int px, input int py, input int ch);
        int base;
        int v;
        base = (ch < 4) ? 147 : ((ch < 12) ? 149 : 150);
        v = base + px * (ch + 1) + py * (2 * ch + 3);
        return v[7:0];
    endfunction

    always_comb begin
        for (int ch = 0; ch < 16; ch++) begin
            delta[ch] = delta_f(int'(p_x), int'(p_y), ch);
        end
    end

    function automatic int exp_pix(input int px, input int py);
        int s;
        s = 0;
        for (int ch = 0; ch < 16; ch++) begin
            s += frame[ch][delta_f(px, py, ch)];
        end
        return (s < 0) ? -s : s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < 16; ch++)
            for (int n = 0; n < 256; n++)
                frame[ch][n] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Start, then feed 256 valid samples with random gaps and garbage in the gaps.
    task automatic capture();
        int n;
        start = 1'b1;
        sval  = 1'b1;
        for (int ch = 0; ch < 16; ch++) samp[ch] = 12'($urandom);
        step();
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL capture_busy: got %0b want 1", busy);
        else n_pass++;
        n = 0;
        while (n < 256) begin
            sval = ($urandom_range(0, 3) != 0);
            for (int ch = 0; ch < 16; ch++)
                samp[ch] = sval ? 12'(frame[ch][n]) : 12'($urandom);
            step();
            if (sval) n++;
        end
        sval = 1'b0;
    endtask

    // Consume one full scan starting at the first SETUP cycle, checking every handshake.
    task automatic run_scan(input bit tie_ready, input int exp_const, input bit chk_center,
                            input bit noise);
        int  hs, smp, last_s, done_cnt, ex_x, ex_y;
        bit  finished, holding, r;
        logic [15:0] h_data;
        logic signed [1:0] h_x, h_y;
        hs = 0; smp = 0; last_s = -1; done_cnt = 0; ex_x = XMIN; ex_y = YMIN;
        finished = 0; holding = 0; h_data = '0; h_x = '0; h_y = '0;
        while (!finished && smp < 2000) begin
            if (holding) begin
                n_total++;
                if (pvalid !== 1'b1 || pdata !== h_data || pix_x !== h_x || pix_y !== h_y)
                    $display("FAIL scan_hold: got v=%0b d=%0d x=%0d y=%0d want v=1 d=%0d x=%0d y=%0d",
                             pvalid, pdata, pix_x, pix_y, h_data, h_x, h_y);
                else n_pass++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                finished = 1;
                n_total++;
                if (smp != last_s + 1 || hs != NPIX || busy !== 1'b0)
                    $display("FAIL done_timing: got smp=%0d hs=%0d busy=%0b want smp=%0d hs=%0d busy=0",
                             smp, hs, busy, last_s + 1, NPIX);
                else n_pass++;
            end
            r = tie_ready ? 1'b1 : 1'($urandom_range(0, 1));
            if (pvalid === 1'b1 && r) begin
                n_total++;
                if (int'(pix_x) != ex_x || int'(pix_y) != ex_y || int'(pdata) != exp_pix(ex_x, ex_y))
                    $display("FAIL pixel: got (%0d,%0d)=%0d want (%0d,%0d)=%0d",
                             pix_x, pix_y, pdata, ex_x, ex_y, exp_pix(ex_x, ex_y));
                else n_pass++;
                if (exp_const >= 0) begin
                    n_total++;
                    if (int'(pdata) != exp_const)
                        $display("FAIL pixel_const: got %0d want %0d", pdata, exp_const);
                    else n_pass++;
                end
                if (chk_center && ex_x == 0 && ex_y == 0) begin
                    n_total++;
                    if (int'(pdata) != 332) $display("FAIL ramp_center: got %0d want 332", pdata);
                    else n_pass++;
                end
                if (tie_ready) begin
                    n_total++;
                    if ((hs == 0 && smp != 3) || (hs != 0 && smp - last_s != 4))
                        $display("FAIL pixel_spacing: got smp=%0d last=%0d hs=%0d want 3 then +4",
                                 smp, last_s, hs);
                    else n_pass++;
                end
                hs++;
                last_s = smp;
                ex_x++;
                if (ex_x > XMAX) begin
                    ex_x = XMIN;
                    ex_y++;
                end
                holding = 0;
            end else if (pvalid === 1'b1) begin
                holding = 1;
                h_data = pdata; h_x = pix_x; h_y = pix_y;
            end else begin
                holding = 0;
            end
            if (noise) begin
                sval  = 1'b1;
                start = (smp == 10);
                for (int ch = 0; ch < 16; ch++) samp[ch] = 12'($urandom);
            end
            pready = r;
            step();
            smp++;
        end
        start = 1'b0; sval = 1'b0; pready = 1'b0;
        n_total++;
        if (done_cnt != 1 || hs != NPIX)
            $display("FAIL scan_complete: got done=%0d hs=%0d want done=1 hs=%0d", done_cnt, hs, NPIX);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0 || pvalid !== 1'b0)
                $display("FAIL post_idle: got done=%0b busy=%0b valid=%0b want 0 0 0", done, busy, pvalid);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sval = 1'b0; pready = 1'b0; samp = '0;
        step(); step();
        n_total++;
        if ({busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y} !== RST_VEC)
            $display("FAIL reset_vals: got %h want %h",
                     {busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y}, RST_VEC);
        else n_pass++;
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        sval = 1'b1;
        for (int k = 0; k < 5; k++) step();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y} !== RST_VEC)
            $display("FAIL reset_async: got %h want %h",
                     {busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y}, RST_VEC);
        else n_pass++;
        sval = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        for (int ch = 0; ch < 16; ch++)
            for (int n = 0; n < 256; n++) frame[ch][n] = n - 128;
        capture();
        run_scan(1'b1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_neg_extreme();
        for (int ch = 0; ch < 16; ch++)
            for (int n = 0; n < 256; n++) frame[ch][n] = -2048;
        capture();
        run_scan(1'b1, 32768, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int w;
        logic [15:0] d0;
        logic signed [1:0] x0, y0;
        fill_random();
        capture();
        pready = 1'b0;
        w = 0;
        while (pvalid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_total++;
        if (pvalid !== 1'b1 || int'(pdata) != exp_pix(XMIN, YMIN))
            $display("FAIL bp_first: got v=%0b d=%0d want v=1 d=%0d", pvalid, pdata, exp_pix(XMIN, YMIN));
        else n_pass++;
        d0 = pdata; x0 = pix_x; y0 = pix_y;
        for (int k = 0; k < 5; k++) begin
            step();
            n_total++;
            if (pvalid !== 1'b1 || pdata !== d0 || pix_x !== x0 || pix_y !== y0 ||
                int'(p_x) != XMIN)
                $display("FAIL bp_hold: got v=%0b d=%0d x=%0d y=%0d p_x=%0d want v=1 d=%0d x=%0d y=%0d p_x=%0d",
                         pvalid, pdata, pix_x, pix_y, p_x, d0, x0, y0, XMIN);
            else n_pass++;
        end
        pready = 1'b1;
        step();
        pready = 1'b0;
        n_total++;
        if (pvalid !== 1'b0 || int'(p_x) != XMIN + 1 || int'(p_y) != YMIN)
            $display("FAIL bp_release: got v=%0b p=(%0d,%0d) want v=0 p=(%0d,%0d)",
                     pvalid, p_x, p_y, XMIN + 1, YMIN);
        else n_pass++;
        w = 0;
        while (pvalid !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_total++;
        if (pvalid !== 1'b1 || int'(pix_x) != XMIN + 1 || int'(pdata) != exp_pix(XMIN + 1, YMIN))
            $display("FAIL bp_second: got v=%0b x=%0d d=%0d want v=1 x=%0d d=%0d",
                     pvalid, pix_x, pdata, XMIN + 1, exp_pix(XMIN + 1, YMIN));
        else n_pass++;
        do_reset();
    endtask

    task automatic test_random_ready();
        fill_random();
        capture();
        run_scan(1'b0, -1, 1'b0, 1'b1);
    endtask

    task automatic test_start_midscan();
        fill_random();
        capture();
        run_scan(1'b1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midscan();
        fill_random();
        capture();
        pready = 1'b1;
        for (int k = 0; k < 9; k++) step();
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y} !== RST_VEC)
            $display("FAIL reset_midscan: got %h want %h",
                     {busy, pvalid, done, pdata, pix_x, pix_y, p_x, p_y}, RST_VEC);
        else n_pass++;
        pready = 1'b0;
        step();
        rst = 1'b0;
        fill_random();
        capture();
        run_scan(1'b1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_ramp();
        test_neg_extreme();
        test_backpressure();
        test_random_ready();
        test_start_midscan();
        test_reset_midscan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
